// File: rtl/div_pkg.sv
// Shared constants and types for the divider front end.
// Contents: operand/byte geometry, packed-word field offsets, and the
// deserializer FSM state type. No ports.
package div_pkg;
  localparam int WIDTH      = 32;
  localparam int BYTE_W     = 8;
  localparam int NBYTES     = 2 * WIDTH / BYTE_W;
  localparam int CNT_W      = $clog2(NBYTES);
  localparam int DATA_WIDTH = 2 * WIDTH + 1;

  // Packed word layout: {sign, z[31:0], d[31:0]}
  localparam int SIGN_BIT = 64;
  localparam int Z_MSB    = 63;
  localparam int D_MSB    = 31;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;
endpackage

// File: rtl/in_deser_if.sv
// Write-side link between the deserializer and the operand FIFO.
// Signals: wr_valid (word pending), wr_ready (FIFO not full),
// wr_data {sign, z, d}.
// Handshake: a word moves on a rising edge where wr_valid and wr_ready are
// both 1. Once raised, wr_valid stays 1 and wr_data stays constant until that
// edge; wr_valid never depends combinationally on wr_ready.
interface in_deser_if;
  import div_pkg::*;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;

  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/in_deser_hold.sv
// Single-entry output holding register for in_deser.
// Ports: clk, rst_n (async active-low); i_load/i_data offer a completed frame;
// wr (master modport) presents the held word; o_drop pulses one cycle when an
// offered frame is discarded because the held word could not leave.
module in_deser_hold
  import div_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_data,
  in_deser_if.master            wr,
  output logic                  o_drop
);
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_drop;
  logic                  w_xfer;
  logic                  w_accept;

  assign w_xfer   = r_valid & wr.wr_ready;
  // The slot is free if empty or being emptied at this same edge.
  assign w_accept = i_load & (~r_valid | w_xfer);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_drop <= i_load & ~w_accept;
      if (w_accept) begin
        r_valid <= 1'b1;
        r_data  <= i_data;
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign wr.wr_valid = r_valid;
  assign wr.wr_data  = r_data;
  assign o_drop      = r_drop;
endmodule

// File: rtl/in_deser.sv
// Byte-serial input deserializer in front of the divider operand FIFO.
// Collects 8 bytes MSB first (z[31:0] then d[31:0]), packs {sign, z, d} and
// offers it over the wr interface.
// Ports: clk, rst_n (async active-low), push_in/data_in_in byte strobe and
// byte, sign (sampled with byte 0), wr (master modport: wr_valid, wr_data,
// wr_ready), busy (frame in progress), drop/abort one-cycle pulses,
// dbg_state (current FSM state).
// Optional: IN_DESER_STATS_EN adds saturating frame_cnt (words accepted by
// the FIFO) and drop_cnt (drop plus abort pulses).
module in_deser
  import div_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_in,
  input  logic [BYTE_W-1:0] data_in_in,
  input  logic              sign,
  in_deser_if.master        wr,
  output logic              busy,
  output logic              drop,
  output logic              abort,
`ifdef IN_DESER_STATS_EN
  output logic [15:0]       frame_cnt,
  output logic [15:0]       drop_cnt,
`endif
  output state_t            dbg_state
);
  state_t                 r_state, w_state_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic [2*WIDTH-1:0]     r_shift, w_shift_nxt;
  logic                   r_sign, w_sign_nxt;
  logic                   r_abort, w_abort;
  logic                   w_frame_done;
  logic [DATA_WIDTH-1:0]  w_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_sign  <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
      r_sign  <= w_sign_nxt;
      r_abort <= w_abort;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_shift_nxt  = r_shift;
    w_sign_nxt   = r_sign;
    w_abort      = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (push_in) begin
          w_state_nxt = COLLECT;
          w_cnt_nxt   = CNT_W'(1);
          w_shift_nxt = {r_shift[2*WIDTH-BYTE_W-1:0], data_in_in};
          w_sign_nxt  = sign;
        end
      end
      COLLECT: begin
        if (push_in) begin
          w_shift_nxt = {r_shift[2*WIDTH-BYTE_W-1:0], data_in_in};
          if (r_cnt == CNT_W'(NBYTES - 1)) begin
            // Returning to IDLE lets a byte on the very next cycle open a
            // new frame, so back-to-back frames need no gap.
            w_frame_done = 1'b1;
            w_cnt_nxt    = '0;
            w_state_nxt  = IDLE;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end else begin
          w_abort     = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // The last byte is taken straight from the input so the word is ready at
  // the capturing edge.
  always_comb begin
    w_word                  = '0;
    w_word[SIGN_BIT]        = r_sign;
    w_word[Z_MSB:D_MSB+1]   = w_shift_nxt[2*WIDTH-1:WIDTH];
    w_word[D_MSB:0]         = w_shift_nxt[WIDTH-1:0];
  end

  in_deser_hold u_hold (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_frame_done),
    .i_data (w_word),
    .wr     (wr),
    .o_drop (drop)
  );

  assign busy      = (r_cnt != '0);
  assign abort     = r_abort;
  assign dbg_state = r_state;

`ifdef IN_DESER_STATS_EN
  logic [15:0] r_frame_cnt;
  logic [15:0] r_drop_cnt;
  logic [16:0] w_drop_sum;

  assign w_drop_sum = {1'b0, r_drop_cnt} + {15'd0, drop} + {15'd0, r_abort};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (wr.wr_valid && wr.wr_ready && (r_frame_cnt != 16'hFFFF))
        r_frame_cnt <= r_frame_cnt + 16'd1;
      r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end
  end

  assign frame_cnt = r_frame_cnt;
  assign drop_cnt  = r_drop_cnt;
`endif
endmodule

// File: tb/tb_in_deser.sv
module tb_in_deser;
  import div_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        push_in;
  logic [7:0]  data_in_in;
  logic        sign;
  logic        busy;
  logic        drop;
  logic        abort;
  state_t      dbg_state;
`ifdef IN_DESER_STATS_EN
  logic [15:0] frame_cnt;
  logic [15:0] drop_cnt;
`endif

  in_deser_if u_if ();

  in_deser dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_in    (push_in),
    .data_in_in (data_in_in),
    .sign       (sign),
    .wr         (u_if),
    .busy       (busy),
    .drop       (drop),
    .abort      (abort),
`ifdef IN_DESER_STATS_EN
    .frame_cnt  (frame_cnt),
    .drop_cnt   (drop_cnt),
`endif
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [7:0]  frame_q[$];
  logic [64:0] exp_q[$];
  logic        m_sign;
  logic        m_valid;
  logic [64:0] m_word;
  logic        m_drop;
  logic        m_abort;
  int          m_frames;
  int          m_drops;
  int          total;
  int          bad;

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    frame_q.delete();
    exp_q.delete();
    m_sign   = 1'b0;
    m_valid  = 1'b0;
    m_word   = '0;
    m_drop   = 1'b0;
    m_abort  = 1'b0;
    m_frames = 0;
    m_drops  = 0;
  endtask

  task automatic check_outputs();
    chk("wr_valid", 65'(u_if.wr_valid), 65'(m_valid));
    chk("wr_data", u_if.wr_data, m_word);
    chk("busy", 65'(busy), 65'(frame_q.size() != 0));
    chk("drop", 65'(drop), 65'(m_drop));
    chk("abort", 65'(abort), 65'(m_abort));
`ifdef IN_DESER_STATS_EN
    chk("frame_cnt", 65'(frame_cnt), 65'((m_frames > 65535) ? 65535 : m_frames));
    chk("drop_cnt", 65'(drop_cnt), 65'((m_drops > 65535) ? 65535 : m_drops));
`endif
  endtask

  // driver: one clock cycle with given inputs, model update, output check
  task automatic step(input logic p, input logic [7:0] b, input logic s, input logic rdy);
    logic        obs_v;
    logic [64:0] obs_d;
    logic        xfer;
    logic        done;
    logic [63:0] acc;
    logic [64:0] word;
    push_in    = p;
    data_in_in = b;
    sign       = s;
    u_if.wr_ready = rdy;
    #1;
    obs_v = u_if.wr_valid;
    obs_d = u_if.wr_data;
    @(posedge clk);
    // scoreboard: every word the FIFO takes must be the oldest expected one
    if (obs_v && rdy) begin
      if (exp_q.size() != 0) chk("sb_word", obs_d, exp_q.pop_front());
      else chk("sb_count", 65'(exp_q.size()), 65'd1);
    end
    xfer    = m_valid && rdy;
    done    = 1'b0;
    word    = '0;
    m_drop  = 1'b0;
    m_abort = 1'b0;
    if (p) begin
      if (frame_q.size() == 0) m_sign = s;
      frame_q.push_back(b);
      if (frame_q.size() == 8) begin
        acc = '0;
        for (int i = 0; i < 8; i++) acc = {acc[55:0], frame_q[i]};
        word = {m_sign, acc};
        done = 1'b1;
        frame_q.delete();
      end
    end else if (frame_q.size() != 0) begin
      m_abort = 1'b1;
      frame_q.delete();
    end
    if (xfer) m_frames++;
    if (done) begin
      if (!m_valid || xfer) begin
        m_valid = 1'b1;
        m_word  = word;
        exp_q.push_back(word);
      end else begin
        m_drop = 1'b1;
      end
    end else if (xfer) begin
      m_valid = 1'b0;
    end
    if (m_drop) m_drops++;
    if (m_abort) m_drops++;
    #1;
    check_outputs();
  endtask

  task automatic send_frame(input logic [63:0] bytes, input logic s, input logic rdy);
    for (int i = 0; i < 8; i++) step(1'b1, bytes[63-8*i -: 8], s, rdy);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), rdy);
  endtask

  logic [63:0] rnd;

  initial begin
    total = 0;
    bad   = 0;
    model_clear();
    rst_n = 1'b0;
    push_in = 1'b0;
    data_in_in = '0;
    sign = 1'b0;
    u_if.wr_ready = 1'b0;
    #12;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // single frame
    step(1'b1, 8'hcf, 1'b0, 1'b1);
    step(1'b1, 8'hff, 1'b1, 1'b1);
    step(1'b1, 8'h12, 1'b1, 1'b1);
    step(1'b1, 8'h34, 1'b1, 1'b1);
    step(1'b1, 8'h01, 1'b0, 1'b1);
    step(1'b1, 8'h56, 1'b0, 1'b1);
    step(1'b1, 8'h78, 1'b1, 1'b1);
    step(1'b1, 8'h9a, 1'b0, 1'b1);
    chk("tp_single_word", u_if.wr_data, 65'h0_cfff1234_0156789a);
    chk("tp_single_valid", 65'(u_if.wr_valid), 65'd1);
    idle(3, 1'b1);

    // back-to-back frames, second with sign=1
    rnd = {$urandom, $urandom};
    send_frame(rnd, 1'b0, 1'b1);
    send_frame(64'h3f800000_40000000, 1'b1, 1'b1);
    chk("tp_b2b_word", u_if.wr_data, 65'h1_3f800000_40000000);
    idle(3, 1'b1);

    // back-pressure across two frames, then release
    rnd = {$urandom, $urandom};
    send_frame(rnd, 1'b1, 1'b0);
    send_frame({$urandom, $urandom}, 1'b0, 1'b0);
    chk("tp_bp_drop", 65'(drop), 65'd1);
    chk("tp_bp_held", u_if.wr_data, {1'b1, rnd});
    idle(1, 1'b0);
    idle(1, 1'b1);
    chk("tp_bp_released", 65'(u_if.wr_valid), 65'd0);
    idle(2, 1'b1);

    // abort after five bytes, then a clean frame
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("tp_abort", 65'(abort), 65'd1);
    send_frame(64'h01234567_89abcdef, 1'b0, 1'b1);
    chk("tp_after_abort", u_if.wr_data, 65'h0_01234567_89abcdef);
    idle(2, 1'b1);

    // async reset after three bytes, asserted between edges
    send_frame(64'h1111_2222_3333_4444, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    #2;
    rst_n   = 1'b0;
    push_in = 1'b0;
    #1;
    model_clear();
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(64'hdeadbeef_00c0ffee, 1'b1, 1'b1);
    chk("tp_after_reset", u_if.wr_data, 65'h1_deadbeef_00c0ffee);
    idle(2, 1'b1);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 9) != 0), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));

    // drain
    idle(4, 1'b1);
    chk("sb_drain", 65'(exp_q.size()), 65'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
